// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Optional sign-magnitude result correction is enabled by defining BCD_SUB_SIGN_MAG_EN.
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q, b_q, diff_q;
  logic          brw_q, bout_q, err_q;
  logic          bad_digit;
  logic [3:0]    dig_m, dig_s, dig_res;
  logic signed [4:0] dig_t;
  logic          brw_n;
  logic          last_digit;

  // Any operand digit above 9 makes the whole operation invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared single-digit borrow subtractor; FIX reuses it to compute 0 - diff.
  always_comb begin
    dig_m = a_q[4*int'(idx_q) +: 4];
    dig_s = b_q[4*int'(idx_q) +: 4];
`ifdef BCD_SUB_SIGN_MAG_EN
    if (state_q == ST_FIX) begin
      dig_m = 4'd0;
      dig_s = diff_q[4*int'(idx_q) +: 4];
    end
`endif
    dig_t = $signed({1'b0, dig_m}) - $signed({1'b0, dig_s}) - $signed({4'b0000, brw_q});
    if (dig_t < 0) begin
      dig_res = 4'(dig_t + 5'sd10);
      brw_n   = 1'b1;
    end else begin
      dig_res = dig_t[3:0];
      brw_n   = 1'b0;
    end
  end

  assign last_digit = (idx_q == IW'(DIGITS - 1));

`ifdef BCD_SUB_SIGN_MAG_EN
  logic neg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            err_q   <= bad_digit;
            idx_q   <= '0;
`ifdef BCD_SUB_SIGN_MAG_EN
            neg_q   <= 1'b0;
`endif
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (err_q) begin
            // Invalid operands: diff and bout stay cleared.
            state_q <= ST_DONE;
          end else begin
            diff_q[4*int'(idx_q) +: 4] <= dig_res;
            brw_q <= brw_n;
            if (last_digit) begin
              bout_q <= brw_n;
              idx_q  <= '0;
`ifdef BCD_SUB_SIGN_MAG_EN
              if (brw_n) begin
                brw_q   <= 1'b0;
                state_q <= ST_FIX;
              end else begin
                state_q <= ST_DONE;
              end
`else
              state_q <= ST_DONE;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
`ifdef BCD_SUB_SIGN_MAG_EN
        ST_FIX: begin
          diff_q[4*int'(idx_q) +: 4] <= dig_res;
          brw_q <= brw_n;
          if (last_digit) begin
            idx_q   <= '0;
            neg_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_SUB) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign err  = err_q;
`ifdef BCD_SUB_SIGN_MAG_EN
  assign neg  = neg_q;
`else
  assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4): directed cases plus random
// operands checked against an integer-arithmetic reference model.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        op_bin = 1'b0;
  logic        busy, done, bout, neg, err;
  logic [15:0] diff;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (op_a),
    .b    (op_b),
    .bin  (op_bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .neg  (neg),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [15:0] v);
    bit r = 0;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) r = 1;
    return r;
  endfunction

  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] ed, output logic eb, output logic en,
                       output logic ee, output int lat);
    int r;
    if (has_bad(ma) || has_bad(mb)) begin
      ed = '0; eb = 0; en = 0; ee = 1; lat = 1;
    end else begin
      ee = 0;
      r = bcd2int(ma) - bcd2int(mb) - int'(mbin);
      if (r < 0) begin
        eb = 1;
`ifdef BCD_SUB_SIGN_MAG_EN
        ed = int2bcd((-r) % 10000); en = 1; lat = 8;
`else
        ed = int2bcd(r + 10000); en = 0; lat = 4;
`endif
      end else begin
        ed = int2bcd(r); eb = 0; en = 0; lat = 4;
      end
    end
  endtask

  task automatic launch(input logic [15:0] la, input logic [15:0] lb, input logic lbin);
    op_a = la; op_b = lb; op_bin = lbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20 && done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ra, input logic [15:0] rb,
                        input logic rbin);
    logic [15:0] ed;
    logic eb, en, ee;
    int lat, n;
    model(ra, rb, rbin, ed, eb, en, ee, lat);
    launch(ra, rb, rbin);
    if (!ee) check({tag, ".busy"}, 32'(busy), 32'(1));
    wait_done(n);
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check({tag, ".diff"}, 32'(diff), 32'(ed));
    check({tag, ".bout"}, 32'(bout), 32'(eb));
    check({tag, ".neg"}, 32'(neg), 32'(en));
    check({tag, ".err"}, 32'(err), 32'(ee));
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(done), 32'(0));
    check({tag, ".hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [15:0] ra, rb;
    int n;
    bit saw_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.done", 32'(done), 32'(0));
    check("rst.diff", 32'(diff), 32'(0));
    check("rst.bout", 32'(bout), 32'(0));
    check("rst.neg",  32'(neg),  32'(0));
    check("rst.err",  32'(err),  32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t2", 16'h0042, 16'h0017, 1'b0);
    run_op("t3", 16'h1000, 16'h0999, 1'b1);
    run_op("t4", 16'h0000, 16'h0001, 1'b0);
    run_op("t5", 16'h00A0, 16'h0000, 1'b0);
    run_op("t4b", 16'h0000, 16'h9999, 1'b1);

    // Start during SUB digit 1 must be ignored
    launch(16'h0042, 16'h0017, 1'b0);
    @(posedge clk); #1;
    op_a = 16'h9999; op_b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("t6.lat", 32'(n), 32'(2));
    check("t6.diff", 32'(diff), 32'h0025);
    check("t6.bout", 32'(bout), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    check("t6.idle", 32'(busy), 32'(0));

    // Reset mid-operation at SUB digit 2
    launch(16'h5555, 16'h1234, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6r.diff", 32'(diff), 32'(0));
    check("t6r.busy", 32'(busy), 32'(0));
    check("t6r.done", 32'(done), 32'(0));
    #2;
    rst_n = 1'b1;
    saw_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    check("t6r.nodone", 32'(saw_done), 32'(0));
    run_op("t6r.next", 16'h5555, 16'h1234, 1'b0);

    // Random operands, occasionally with an invalid digit
    for (int k = 0; k < 30; k++) begin
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run_op("rnd", ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
